alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/RISCV_pkg.sv | 47 ++++
 rtl/alu_exec_if.sv | 31 +++
 rtl/alu_core.sv | 29 ++
 rtl/alu_exec.sv | 102 ++++++++++
 tb/tb_alu_exec.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/RISCV_pkg.sv
`default_nettype none
// ============================================================================
// Module   : RISCV_pkg
// Brief    : Shared word type, ALU control encodings and execute-stage states.
// Revision : 1.0  initial release
// ============================================================================
package RISCV_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_t;

    function automatic logic is_shift(input alu_ctrl_t ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

    // One-bit step of the iterative shifter.
    function automatic word_t shift1(input alu_ctrl_t ctrl, input word_t v);
        word_t r;
        case (ctrl)
            ALU_SLL: r = {v[XLEN-2:0], 1'b0};
            ALU_SRL: r = {1'b0, v[XLEN-1:1]};
            ALU_SRA: r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_if
// Brief    : Valid/ready operation and result bundle for the execute stage.
// Revision : 1.0  initial release
// ============================================================================
interface alu_exec_if;
    import RISCV_pkg::*;

    logic      in_valid;
    logic      in_ready;
    word_t     op_a;
    word_t     op_b;
    alu_ctrl_t alu_ctrl;
    logic      out_valid;
    logic      out_ready;
    word_t     result;
    logic      zero;

    modport master (
        output in_valid, op_a, op_b, alu_ctrl, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op_a, op_b, alu_ctrl, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational single-cycle ALU (ADD/SUB/AND/OR/XOR).
// Revision : 1.0  initial release
// ============================================================================
module alu_core
    import RISCV_pkg::*;
(
    input  word_t     i_a,
    input  word_t     i_b,
    input  alu_ctrl_t i_ctrl,
    output word_t     o_y
);

    // Unlisted encodings fall through to ADD.
    always_comb begin
        o_y = i_a + i_b;
        case (i_ctrl)
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            default: o_y = i_a + i_b;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Brief    : Execute stage: single-cycle ALU plus one-bit-per-cycle shifter.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec
    import RISCV_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_exec_if.slave   bus
);

    exec_state_t        r_state;
    alu_ctrl_t          r_ctrl;
    word_t              r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    word_t              r_result;
    logic               r_zero;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_multi;
    logic [SHAMT_W-1:0] w_shamt;
    word_t              w_core_y;
    word_t              w_single;
    word_t              w_shift_next;

    alu_core u_core (
        .i_a    (bus.op_a),
        .i_b    (bus.op_b),
        .i_ctrl (bus.alu_ctrl),
        .o_y    (w_core_y)
    );

    assign w_in_ready   = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_shamt      = bus.op_b[SHAMT_W-1:0];
    assign w_multi      = is_shift(bus.alu_ctrl) && (w_shamt != '0);
    // A zero-distance shift degenerates to a pass-through of op_a.
    assign w_single     = is_shift(bus.alu_ctrl) ? bus.op_a : w_core_y;
    assign w_shift_next = shift1(r_ctrl, r_acc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ctrl      <= ALU_ADD;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_state     <= SHIFT;
                            r_ctrl      <= bus.alu_ctrl;
                            r_acc       <= bus.op_a;
                            r_cnt       <= w_shamt;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= DONE;
                            r_result    <= w_single;
                            r_zero      <= (w_single == '0);
                            r_out_valid <= 1'b1;
                        end
                    end else if ((r_state == DONE) && bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_acc <= w_shift_next;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state     <= DONE;
                        r_result    <= w_shift_next;
                        r_zero      <= (w_shift_next == '0);
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec
// Brief    : Directed plus randomized checks of alu_exec against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec;
    import RISCV_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_exec_if bus ();

    alu_exec #(.SHAMT_W(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t ref_result(input logic [3:0] c, input word_t a, input word_t b);
        int    sh;
        word_t r;
        sh = int'(b[4:0]);
        case (c)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SUB: r = a - b;
            ALU_SLL: r = a << sh;
            ALU_SRL: r = a >> sh;
            ALU_SRA: r = word_t'($signed(a) >>> sh);
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] c, input word_t b);
        if ((c == ALU_SLL || c == ALU_SRL || c == ALU_SRA) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input word_t a, input word_t b);
        bus.alu_ctrl = alu_ctrl_t'(c);
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    // Issue one op from IDLE, measure latency, optionally stall the result.
    task automatic run_op(input logic [3:0] c, input word_t a, input word_t b, input int stall);
        word_t er;
        int    el;
        int    n;
        er = ref_result(c, a, b);
        el = ref_latency(c, b);
        drive(c, a, b);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 64) begin
            tick();
            n++;
        end
        check_eq("latency", 32'(n), 32'(el));
        check_eq("result", bus.result, er);
        check_eq("zero", 32'(bus.zero), 32'(er == '0));
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
                check_eq("stall_result", bus.result, er);
                check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
            #1;
            check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
        end
        tick();
        check_eq("retire_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_b2b(input logic [3:0] c0, input word_t a0, input word_t b0,
                           input logic [3:0] c1, input word_t a1, input word_t b1,
                           input logic [3:0] c2, input word_t a2, input word_t b2);
        logic [3:0] cs [3];
        word_t      as [3];
        word_t      bs [3];
        word_t      er;
        cs[0] = c0; cs[1] = c1; cs[2] = c2;
        as[0] = a0; as[1] = a1; as[2] = a2;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(cs[k], as[k], bs[k]);
            tick();
            er = ref_result(cs[k], as[k], bs[k]);
            check_eq("b2b_valid", 32'(bus.out_valid), 32'd1);
            check_eq("b2b_result", bus.result, er);
            check_eq("b2b_zero", 32'(bus.zero), 32'(er == '0));
        end
        bus.in_valid = 1'b0;
        tick();
        check_eq("b2b_end_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [8];
        logic [3:0] c;
        word_t      a;
        word_t      b;
        int         stale;

        ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND; ops[3] = ALU_OR;
        ops[4] = ALU_XOR; ops[5] = ALU_SLL; ops[6] = ALU_SRL; ops[7] = ALU_SRA;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(ALU_ADD, '0, '0);
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_zero", 32'(bus.zero), 32'd1);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;

        // Directed single-cycle and shift cases.
        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(ALU_SUB, 32'd5, 32'd3, 0);
        run_op(ALU_SRA, 32'h8000_0000, 32'd4, 0);
        run_op(ALU_SRL, 32'h8000_0000, 32'd4, 0);
        run_op(ALU_SLL, 32'h0000_0001, 32'h0000_0025, 0);
        run_op(ALU_SRA, 32'h8765_4321, 32'h0000_0020, 0);
        run_op(ALU_SLL, 32'h0000_0001, 32'h0000_001F, 0);
        run_op(4'b1111, 32'd10, 32'd20, 0);
        run_op(ALU_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4);

        run_b2b(ALU_ADD, 32'd1, 32'd1, ALU_OR, 32'h0C, 32'h03, ALU_AND, 32'h0C, 32'h03);
        run_b2b(ALU_SUB, 32'd9, 32'd9, ALU_XOR, 32'hA5, 32'h5A, 4'b1010, 32'd3, 32'd4);

        // Operation held upstream while a shift is in flight.
        bus.out_ready = 1'b1;
        drive(ALU_SLL, 32'h0000_0003, 32'd3);
        bus.in_valid = 1'b1;
        tick();
        drive(ALU_ADD, 32'd7, 32'd8);
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("hold_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        check_eq("hold_shift_valid", 32'(bus.out_valid), 32'd1);
        check_eq("hold_shift_result", bus.result, 32'h0000_0018);
        tick();
        bus.in_valid = 1'b0;
        check_eq("hold_add_valid", 32'(bus.out_valid), 32'd1);
        check_eq("hold_add_result", bus.result, 32'd15);
        check_eq("hold_add_zero", 32'(bus.zero), 32'd0);
        tick();
        check_eq("hold_end_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a long shift.
        drive(ALU_SLL, 32'h0000_0001, 32'd20);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_result", bus.result, 32'd0);
        check_eq("midrst_zero", 32'(bus.zero), 32'd1);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.out_valid) stale++;
        end
        check_eq("midrst_no_stale", 32'(stale), 32'd0);

        // Randomized operations against the reference model.
        for (int t = 0; t < 60; t++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            c   = (sel < 8) ? ops[sel] : 4'($urandom_range(8, 15));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 5) == 0) b[4:0] = 5'd0;
            run_op(c, a, b, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
